// File: rtl/dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_mac_sequencer
//  Purpose  : Feeds operand beats into a pipelined DSP multiply-accumulate
//             slice, steers its OPMODE so the first beat of a frame restarts
//             the accumulator, waits out the slice latency and returns the
//             accumulated frame result over a valid/ready handshake.
//  Options  : define MAC_SEQ_SAT_EN to saturate results wider than ACC_W bits
//             to 2^ACC_W-1 and flag them on r_ovf_o.
//  Revision : 1.0 - initial release
// ============================================================================
module dsp_mac_sequencer #(
    parameter int LAT     = 3,   // operand edge to P contribution, cycles
    parameter int OPM_DLY = 1,   // OPMODE lag behind its operands, cycles
    parameter int MAX_LEN = 16,  // beats per frame before forced close
    parameter int ACC_W   = 40   // result width for overflow detection
) (
    input  logic        clk,
    input  logic        rst_n,
    // operand stream
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [17:0] s_a_i,
    input  logic [17:0] s_b_i,
    input  logic        s_last_i,
    // DSP slice
    output logic [17:0] dsp_a_o,
    output logic [17:0] dsp_b_o,
    output logic [7:0]  dsp_opmode_o,
    input  logic [47:0] dsp_p_i,
    // result stream
    output logic        r_valid_o,
    input  logic        r_ready_i,
    output logic [47:0] r_data_o,
    output logic        r_ovf_o,
    output logic        r_err_o
);

    localparam int CNT_W  = $clog2(MAX_LEN + 1);
    localparam int DCNT_W = $clog2(LAT + 1) + 1;

    localparam logic [7:0] OPM_LOAD = 8'h01;  // P = M
    localparam logic [7:0] OPM_ACC  = 8'h09;  // P = P + M

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic                err_pend_q, err_pend_d;
    logic                rdy_en_q;
    logic [17:0]         dsp_a_q, dsp_a_d;
    logic [17:0]         dsp_b_q, dsp_b_d;
    logic [7:0]          opm_d;
    logic [7:0]          opm_q [OPM_DLY+1];
    logic                r_valid_q, r_valid_d;
    logic [47:0]         r_data_q, r_data_d;
    logic                r_ovf_q, r_ovf_d;
    logic                r_err_q, r_err_d;

    logic                accept;
    logic                frame_end;
    logic [47:0]         p_result;
    logic                p_ovf;

    // Result conditioning applied to the slice output at sampling time
`ifdef MAC_SEQ_SAT_EN
    assign p_ovf    = |dsp_p_i[47:ACC_W];
    assign p_result = p_ovf ? {{(48-ACC_W){1'b0}}, {ACC_W{1'b1}}} : dsp_p_i;
`else
    assign p_ovf    = 1'b0;
    assign p_result = dsp_p_i;
`endif

    // Upstream may only transfer while a frame is being collected; held off
    // during the first cycle after reset release.
    assign s_ready_o = rdy_en_q && ((state_q == ST_IDLE) || (state_q == ST_FEED));
    assign accept    = s_valid_i && s_ready_o;
    assign frame_end = accept && (s_last_i || (cnt_q == CNT_W'(MAX_LEN - 1)));

    // Next-state, beat bookkeeping and result capture
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dcnt_d     = dcnt_q;
        err_pend_d = err_pend_q;
        r_valid_d  = r_valid_q;
        r_data_d   = r_data_q;
        r_ovf_d    = r_ovf_q;
        r_err_d    = r_err_q;
        // Non-beat cycles push zero operands so the slice adds nothing.
        dsp_a_d    = accept ? s_a_i : 18'd0;
        dsp_b_d    = accept ? s_b_i : 18'd0;
        // Only the opening beat of a frame reloads the accumulator.
        opm_d      = (accept && (state_q == ST_IDLE)) ? OPM_LOAD : OPM_ACC;

        unique case (state_q)
            ST_IDLE, ST_FEED: begin
                if (accept) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_FEED;
                    if (frame_end) begin
                        state_d    = ST_DRAIN;
                        cnt_d      = '0;
                        dcnt_d     = '0;
                        err_pend_d = !s_last_i;
                    end
                end
            end
            ST_DRAIN: begin
                dcnt_d = dcnt_q + DCNT_W'(1);
                // The LAT+1-th edge after the last beat sees its contribution.
                if (dcnt_q == DCNT_W'(LAT)) begin
                    state_d   = ST_HOLD;
                    r_valid_d = 1'b1;
                    r_data_d  = p_result;
                    r_ovf_d   = p_ovf;
                    r_err_d   = err_pend_q;
                end
            end
            ST_HOLD: begin
                if (r_ready_i) begin
                    r_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dcnt_q     <= '0;
            err_pend_q <= 1'b0;
            rdy_en_q   <= 1'b0;
            dsp_a_q    <= '0;
            dsp_b_q    <= '0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_ovf_q    <= 1'b0;
            r_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dcnt_q     <= dcnt_d;
            err_pend_q <= err_pend_d;
            rdy_en_q   <= 1'b1;
            dsp_a_q    <= dsp_a_d;
            dsp_b_q    <= dsp_b_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            r_ovf_q    <= r_ovf_d;
            r_err_q    <= r_err_d;
        end
    end

    // OPMODE delay line: stage 0 aligns with the operands, the last stage
    // trails them by OPM_DLY cycles to match the slice's internal pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= OPM_DLY; i++) opm_q[i] <= 8'h00;
        end else begin
            opm_q[0] <= opm_d;
            for (int i = 1; i <= OPM_DLY; i++) opm_q[i] <= opm_q[i-1];
        end
    end

    assign dsp_a_o      = dsp_a_q;
    assign dsp_b_o      = dsp_b_q;
    assign dsp_opmode_o = opm_q[OPM_DLY];
    assign r_valid_o    = r_valid_q;
    assign r_data_o     = r_data_q;
    assign r_ovf_o      = r_ovf_q;
    assign r_err_o      = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dsp_mac_sequencer
//  Purpose  : Directed and randomized checks of dsp_mac_sequencer against a
//             frame-sum reference, with a cycle model of the DSP slice.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_mac_sequencer;

    localparam int LAT     = 3;
    localparam int OPM_DLY = 1;
    localparam int MAX_LEN = 16;
`ifdef MAC_SEQ_SAT_EN
    localparam int ACC_W   = 36;
`else
    localparam int ACC_W   = 40;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid, s_ready, s_last;
    logic [17:0] s_a, s_b;
    logic [17:0] dsp_a, dsp_b;
    logic [7:0]  dsp_opm;
    logic [47:0] dsp_p;
    logic        r_valid, r_ready, r_ovf, r_err;
    logic [47:0] r_data;

    int          n_vec = 0;
    int          n_err = 0;
    longint      cyc = 0;
    longint      last_acc = 0;
    logic [47:0] ref_sum = '0;

    dsp_mac_sequencer #(
        .LAT(LAT), .OPM_DLY(OPM_DLY), .MAX_LEN(MAX_LEN), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid_i(s_valid), .s_ready_o(s_ready),
        .s_a_i(s_a), .s_b_i(s_b), .s_last_i(s_last),
        .dsp_a_o(dsp_a), .dsp_b_o(dsp_b), .dsp_opmode_o(dsp_opm),
        .dsp_p_i(dsp_p),
        .r_valid_o(r_valid), .r_ready_i(r_ready),
        .r_data_o(r_data), .r_ovf_o(r_ovf), .r_err_o(r_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // DSP slice: operands registered at edge t contribute to P after edge
    // t+LAT, using the OPMODE presented OPM_DLY edges after those operands.
    logic [47:0] ph[$];
    logic [7:0]  oh[$];
    logic [47:0] p_acc;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph.delete(); oh.delete();
            p_acc = '0;
            dsp_p = '0;
        end else begin
            ph.push_back(48'(dsp_a) * 48'(dsp_b));
            oh.push_back(dsp_opm);
            if (ph.size() > LAT) begin
                case (oh[OPM_DLY])
                    8'h01:   p_acc = ph[0];
                    8'h09:   p_acc = p_acc + ph[0];
                    default: p_acc = '0;
                endcase
                void'(ph.pop_front());
                void'(oh.pop_front());
                dsp_p = p_acc;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] exp_data(input logic [47:0] sum);
`ifdef MAC_SEQ_SAT_EN
        if ((sum >> ACC_W) != 48'd0) return (48'd1 << ACC_W) - 48'd1;
`endif
        return sum;
    endfunction

    function automatic logic exp_ovf(input logic [47:0] sum);
`ifdef MAC_SEQ_SAT_EN
        return (sum >> ACC_W) != 48'd0;
`else
        return sum != sum;
`endif
    endfunction

    // Offer one beat until it is taken; starts and ends just after a negedge.
    task automatic drive_beat(input logic [17:0] a, input logic [17:0] b, input logic last);
        logic rdy;
        int   k = 0;
        s_valid = 1'b1; s_a = a; s_b = b; s_last = last;
        do begin
            rdy = s_ready;
            @(posedge clk); @(negedge clk);
            k++;
        end while (!rdy && k < 100);
        chk("beat_accept", 64'(rdy), 64'd1);
        if (rdy) begin
            ref_sum  = ref_sum + 48'(a) * 48'(b);
            last_acc = cyc;
        end
        s_valid = 1'b0;
        s_a = 18'($urandom); s_b = 18'($urandom); s_last = 1'($urandom);
    endtask

    task automatic bubble();
        s_valid = 1'b0;
        chk("ready_in_feed", 64'(s_ready), 64'd1);
        @(posedge clk); @(negedge clk);
    endtask

    // Collect one result, hold it off for 'hold' cycles, then complete it.
    task automatic wait_result(input logic err, input int hold);
        logic [47:0] d0;
        int k = 0;
        while (!r_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("r_valid_seen", 64'(r_valid), 64'd1);
        chk("latency", 64'(cyc - last_acc), 64'(LAT + 1));
        chk("r_data", 64'(r_data), 64'(exp_data(ref_sum)));
        chk("r_ovf", 64'(r_ovf), 64'(exp_ovf(ref_sum)));
        chk("r_err", 64'(r_err), 64'(err));
        chk("ready_in_hold", 64'(s_ready), 64'd0);
        d0 = r_data;
        repeat (hold) begin
            @(negedge clk);
            chk("stall_valid", 64'(r_valid), 64'd1);
            chk("stall_data", 64'(r_data), 64'(d0));
            chk("stall_ready", 64'(s_ready), 64'd0);
        end
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        chk("valid_drop", 64'(r_valid), 64'd0);
        ref_sum = '0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_dsp_a", 64'(dsp_a), 64'd0);
        chk("rst_dsp_b", 64'(dsp_b), 64'd0);
        chk("rst_opmode", 64'(dsp_opm), 64'd0);
        chk("rst_r_valid", 64'(r_valid), 64'd0);
        chk("rst_r_data", 64'(r_data), 64'd0);
        chk("rst_r_ovf", 64'(r_ovf), 64'd0);
        chk("rst_r_err", 64'(r_err), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0; r_ready = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        chk("ready_before_edge", 64'(s_ready), 64'd0);
        @(negedge clk);
        chk("ready_after_edge", 64'(s_ready), 64'd1);

        // Two-beat frame
        drive_beat(18'd2, 18'd3, 1'b0);
        drive_beat(18'd4, 18'd5, 1'b1);
        chk("sum_26", 64'(ref_sum), 64'd26);
        wait_result(1'b0, 0);

        // Largest operands, single and double beat
        drive_beat(18'h3FFFF, 18'h3FFFF, 1'b1);
        chk("sum_max", 64'(ref_sum), 64'hFFFF80001);
        wait_result(1'b0, 0);
        drive_beat(18'h3FFFF, 18'h3FFFF, 1'b0);
        drive_beat(18'h3FFFF, 18'h3FFFF, 1'b1);
        wait_result(1'b0, 1);

        // Bubbles inside a frame add nothing
        drive_beat(18'd1, 18'd1, 1'b0);
        repeat (3) bubble();
        drive_beat(18'd1, 18'd1, 1'b1);
        wait_result(1'b0, 0);

        // Stalled result, then a fresh frame with no carry-over
        drive_beat(18'd6, 18'd6, 1'b1);
        wait_result(1'b0, 5);
        drive_beat(18'd7, 18'd7, 1'b1);
        chk("sum_49", 64'(ref_sum), 64'd49);
        wait_result(1'b0, 0);

        // MAX_LEN beats without last, with beat 17 waiting behind them
        for (int i = 0; i < MAX_LEN; i++) drive_beat(18'd1, 18'd1, 1'b0);
        s_valid = 1'b1; s_a = 18'd1; s_b = 18'd1; s_last = 1'b1;
        wait_result(1'b1, 2);
        drive_beat(18'd1, 18'd1, 1'b1);
        wait_result(1'b0, 0);

        // Reset in the middle of a frame
        drive_beat(18'd5, 18'd6, 1'b0);
        drive_beat(18'd7, 18'd8, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        ref_sum = '0;
        @(negedge clk);
        repeat (8) @(negedge clk);
        chk("no_result_after_reset", 64'(r_valid), 64'd0);
        drive_beat(18'd3, 18'd3, 1'b1);
        wait_result(1'b0, 0);

        // Randomized frames with random bubbles and stalls
        for (int f = 0; f < 25; f++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                if (i != 0 && $urandom_range(0, 9) < 3) bubble();
                drive_beat(18'($urandom_range(0, 18'h3FFFF)), 18'($urandom_range(0, 18'h3FFFF)),
                           (i == len - 1));
            end
            wait_result(1'b0, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsp_mac_sequencer.md
DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 SHALL have parameter LAT, default 3: cycles from a beat's DSP_A/DSP_B update edge to its contribution appearing on DSP_P.
REQ-002 SHALL have parameter OPM_DLY, default 1: cycles DSP_OPMODE for a beat lags that beat's DSP_A/DSP_B.
REQ-003 SHALL have parameter MAX_LEN, default 16: maximum beats per frame.
REQ-004 SHALL have parameter ACC_W, default 40: result width checked by the overflow feature.
REQ-005 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-006 RSTN  in  1  reset, asynchronous assert, active-low.
REQ-007 S_VALID/S_READY  in/out  1/1  upstream operand handshake; a beat transfers when both are high at a CLK edge.
REQ-008 S_A, S_B  in  18 each  unsigned operands; S_LAST  in  1  marks the final beat of a frame.
REQ-009 DSP_A, DSP_B  out  18 each  registered operands to the slice A/B ports.
REQ-010 DSP_OPMODE  out  8  registered opmode to the slice.
REQ-011 DSP_P  in  48  slice P output.
REQ-012 R_VALID/R_READY  out/in  1/1  result handshake; R_DATA  out  48; R_OVF, R_ERR  out  1 each.

Function
REQ-013 States IDLE, FEED, DRAIN, HOLD; IDLE->FEED on first accepted beat; FEED->DRAIN on accepted S_LAST beat or on the MAX_LEN-th beat; DRAIN->HOLD after LAT+1 edges; HOLD->IDLE on R_VALID&&R_READY.
REQ-014 S_READY SHALL be high only in IDLE and FEED.
REQ-015 On an accepted beat, DSP_A/DSP_B SHALL take S_A/S_B; on any other edge they SHALL take 0.
REQ-016 DSP_OPMODE SHALL be 8'h01 (X=M, Z=0) for the first beat of a frame, and 8'h09 (X=M, Z=P) for every other beat, bubble, DRAIN, HOLD and IDLE cycle, delayed OPM_DLY cycles relative to the associated operands.
REQ-017 Bubbles in FEED (S_VALID low) SHALL contribute zero products; the accumulated sum is unaffected.
REQ-018 DSP_P SHALL be sampled into R_DATA at the edge LAT+1 after the edge accepting the last beat; R_VALID SHALL rise on that same edge.
REQ-019 R_DATA, R_OVF and R_ERR SHALL stay stable while R_VALID is high and R_READY is low.
REQ-020 A beat counter SHALL count accepted beats per frame; when it reaches MAX_LEN without S_LAST, the frame ends there and R_ERR=1 for that result; R_ERR=0 otherwise.
REQ-021 A one-beat frame (S_LAST on first beat) SHALL be legal and yield that single product.
REQ-022 The beat accepted in the same cycle as the HOLD->IDLE handshake is impossible (S_READY low); the next frame starts no earlier than the edge after the handshake.

Reset
REQ-023 RSTN low SHALL asynchronously force: state IDLE, counter 0, S_READY 0 then 1 from the first edge after release, DSP_A=DSP_B=0, DSP_OPMODE=8'h00, R_VALID=0, R_DATA=0, R_OVF=0, R_ERR=0.
REQ-024 Reset mid-frame SHALL discard the partial frame; no result is emitted for it.

Configuration
REQ-025 Macro MAC_SEQ_SAT_EN: when defined, if DSP_P[47:ACC_W] is nonzero at sampling, R_DATA SHALL be 2^ACC_W-1 and R_OVF=1, else R_DATA=DSP_P and R_OVF=0.
REQ-026 Without MAC_SEQ_SAT_EN, R_DATA SHALL equal sampled DSP_P unmodified and R_OVF SHALL be constant 0.

Verification (bench uses a cycle model of the slice honouring LAT/OPM_DLY)
REQ-027 Frame (2,3),(4,5,S_LAST), R_READY=1 -> R_DATA=26, R_VALID rises LAT+1 edges after the second beat, R_ERR=0.
REQ-028 Single beat (0x3FFFF,0x3FFFF,S_LAST) -> R_DATA=0xFFFF80001; with MAC_SEQ_SAT_EN and ACC_W=36, two such beats -> R_DATA=0xFFFFFFFFF, R_OVF=1.
REQ-029 Frame (1,1),bubble x3,(1,1,S_LAST) -> R_DATA=2; S_READY high throughout FEED.
REQ-030 R_READY held low 5 cycles after R_VALID -> S_READY=0, R_DATA stable all 5 cycles; second frame (7,7,S_LAST) after handshake -> R_DATA=49 (no carry-over).
REQ-031 17 beats of (1,1) with no S_LAST, MAX_LEN=16 -> R_DATA=16, R_ERR=1; beat 17 starts a new frame -> next result 1.
REQ-032 RSTN pulsed low after 2 beats of a frame -> all outputs at reset values immediately; no result; subsequent frame (3,3,S_LAST) -> R_DATA=9.
